// File: rtl/rr_prio_encode.sv
// Registered priority encoder with run-time fixed / round-robin selection and valid/ready output.
// Optional one-hot grant output enabled by defining RRPE_ONEHOT_EN.
module rr_prio_encode #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDXW-1:0]  op,
  output logic             op_none,
  output logic             op_valid,
  input  logic             out_ready
`ifdef RRPE_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] oh
`endif
);

  localparam logic [IDXW-1:0] PTR_INIT = IDXW'(WIDTH - 1);

  logic [IDXW-1:0]  ptr;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] hi_req;
  logic [IDXW-1:0]  fix_idx;
  logic [IDXW-1:0]  rr_idx;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_none;
  logic             accept;

  function automatic logic [IDXW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDXW'(i);
    end
    return idx;
  endfunction

  // Round robin: prefer the lowest request strictly above ptr; if there is none,
  // the lowest request overall is the wrapped winner (order 0..ptr).
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hi_mask[i] = (i > int'(ptr));
    end
    hi_req   = code & hi_mask;
    fix_idx  = lowest_idx(code);
    rr_idx   = (|hi_req) ? lowest_idx(hi_req) : fix_idx;
    sel_none = ~|code;
    sel_idx  = '0;
    if (!sel_none) sel_idx = mode ? rr_idx : fix_idx;
  end

  assign in_ready = ~clr & (~op_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= PTR_INIT;
      op       <= '0;
      op_none  <= 1'b0;
      op_valid <= 1'b0;
    end else if (clr) begin
      ptr      <= PTR_INIT;
      op_valid <= 1'b0;
    end else if (accept) begin
      op       <= sel_idx;
      op_none  <= sel_none;
      op_valid <= 1'b1;
      if (!sel_none) ptr <= sel_idx;
    end else if (out_ready) begin
      op_valid <= 1'b0;
    end
  end

`ifdef RRPE_ONEHOT_EN
  logic [WIDTH-1:0] sel_oh;

  always_comb begin
    sel_oh = '0;
    if (!sel_none) sel_oh[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oh <= '0;
    end else if (!clr && accept) begin
      oh <= sel_oh;
    end
  end
`endif

endmodule

// File: tb/tb_rr_prio_encode.sv
// Directed self-checking bench for rr_prio_encode (WIDTH=8, IDXW=3).
module tb_rr_prio_encode;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       mode;
  logic [7:0] code;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       op_none;
  logic       op_valid;
  logic       out_ready;
`ifdef RRPE_ONEHOT_EN
  logic [7:0] oh;
`endif

  int total = 0;
  int bad   = 0;

  rr_prio_encode #(.WIDTH(8), .IDXW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mode      (mode),
    .code      (code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_none   (op_none),
    .op_valid  (op_valid),
    .out_ready (out_ready)
`ifdef RRPE_ONEHOT_EN
    ,
    .oh        (oh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("FAIL por_valid got=%b want=0", op_valid); end
    mode = 1'b0; code = 8'h04; in_valid = 1'b1; out_ready = 1'b0;
    step();
    total++;
    if (op_valid !== 1'b1 || op !== 3'd2) begin
      bad++; $display("FAIL pre_reset_load got valid=%b op=%0d want valid=1 op=2", op_valid, op);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (op !== 3'd0 || op_valid !== 1'b0 || op_none !== 1'b0) begin
      bad++; $display("FAIL async_reset got op=%0d valid=%b none=%b want 0/0/0", op, op_valid, op_none);
    end
    #1 rst_n = 1'b1;
    mode = 1'b1; code = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    total++;
    if (op !== 3'd0 || op_valid !== 1'b1) begin
      bad++; $display("FAIL reset_rr_first got op=%0d valid=%b want op=0 valid=1", op, op_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_fixed();
    logic [7:0] codes [3];
    logic [2:0] exp_op [3];
    logic       exp_none [3];
    codes = '{8'b0001_0100, 8'h80, 8'h00};
    exp_op = '{3'd2, 3'd7, 3'd0};
    exp_none = '{1'b0, 1'b0, 1'b1};
    do_reset();
    mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code = codes[i];
      step();
      total++;
      if (op !== exp_op[i] || op_none !== exp_none[i] || op_valid !== 1'b1) begin
        bad++;
        $display("FAIL fixed_%0d got op=%0d none=%b valid=%b want op=%0d none=%b valid=1",
                 i, op, op_none, op_valid, exp_op[i], exp_none[i]);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("FAIL fixed_drain got valid=%b want=0", op_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1; code = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (op !== 3'(i % 8) || op_valid !== 1'b1) begin
        bad++; $display("FAIL rr_ff_%0d got op=%0d valid=%b want op=%0d", i, op, op_valid, i % 8);
      end
    end
    code = 8'b0000_0101;
    step();
    total++;
    if (op !== 3'd2) begin bad++; $display("FAIL rr_05_a got=%0d want=2", op); end
    step();
    total++;
    if (op !== 3'd0) begin bad++; $display("FAIL rr_05_wrap got=%0d want=0", op); end
    // Zero code leaves ptr at 0, so a full request next grants 1.
    code = 8'h00;
    step();
    total++;
    if (op !== 3'd0 || op_none !== 1'b1 || op_valid !== 1'b1) begin
      bad++; $display("FAIL rr_zero got op=%0d none=%b valid=%b want 0/1/1", op, op_none, op_valid);
    end
    code = 8'hFF;
    step();
    total++;
    if (op !== 3'd1 || op_none !== 1'b0) begin
      bad++; $display("FAIL rr_after_zero got op=%0d none=%b want op=1 none=0", op, op_none);
    end
    // Mode switch: fixed picks bit 0 and moves ptr there; round robin then goes to 2.
    mode = 1'b0; code = 8'b0000_0101;
    step();
    total++;
    if (op !== 3'd0) begin bad++; $display("FAIL mode_fixed got=%0d want=0", op); end
    mode = 1'b1;
    step();
    total++;
    if (op !== 3'd2) begin bad++; $display("FAIL mode_rr got=%0d want=2", op); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1; code = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    step();
    total++;
    if (op !== 3'd0 || op_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_load got op=%0d valid=%b in_ready=%b want 0/1/0", op, op_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (op !== 3'd0 || op_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got op=%0d valid=%b in_ready=%b want 0/1/0", i, op, op_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b want=1", in_ready); end
    step();
    total++;
    if (op !== 3'd1 || op_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release got op=%0d valid=%b want op=1 valid=1", op, op_valid);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got valid=%b want=0", op_valid); end
  endtask

  task automatic test_clr();
    do_reset();
    mode = 1'b1; code = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    total++;
    if (op !== 3'd5) begin bad++; $display("FAIL clr_setup got=%0d want=5", op); end
    clr = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%b want=0", in_ready); end
    step();
    total++;
    if (op_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", op_valid); end
    clr = 1'b0;
    step();
    total++;
    if (op !== 3'd0 || op_valid !== 1'b1) begin
      bad++; $display("FAIL clr_next got op=%0d valid=%b want op=0 valid=1", op, op_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef RRPE_ONEHOT_EN
  task automatic test_onehot();
    do_reset();
    mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; code = 8'b0110_0000;
    step();
    total++;
    if (op !== 3'd5 || oh !== 8'h20) begin
      bad++; $display("FAIL oh_bit got op=%0d oh=%h want op=5 oh=20", op, oh);
    end
    code = 8'h00;
    step();
    total++;
    if (oh !== 8'h00 || op_none !== 1'b1) begin
      bad++; $display("FAIL oh_zero got oh=%h none=%b want oh=00 none=1", oh, op_none);
    end
    in_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; code = 8'h00;
    in_valid = 1'b0; out_ready = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_clr();
`ifdef RRPE_ONEHOT_EN
    test_onehot();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_prio_encode.md
# rr_prio_encode

Parametrised, registered priority encoder for the base-address loop. It selects one active bit from a WIDTH-bit request vector (for example, free frame-buffer slots) and returns that bit's index through a valid/ready output register. Two priority modes are selectable at run time:
- **Fixed mode:** the lowest set bit wins.
- **Round-robin mode:** the search starts just after the last granted index and wraps.

The block sits between the buffer-status logic and the base-address generator.

## Interface
Parameters:
- WIDTH, default 8: request vector width, 2..64.
- IDXW, default 3: index width. Must satisfy 2^IDXW >= WIDTH.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear. Clears the round-robin pointer and drops op_valid.
- mode  in  1  0 = fixed lowest-index priority; 1 = round-robin. Sampled with code.
- code  in  WIDTH  request vector.
- in_valid  in  1  code/mode are valid.
- in_ready  out  1  block can accept code this cycle.
- op  out  IDXW  granted index.
- op_none  out  1  the accepted code was all zero.
- op_valid  out  1  op and op_none are valid.
- out_ready  in  1  consumer takes the result.
- oh  out  WIDTH  one-hot grant. Present only with RRPE_ONEHOT_EN.

## Operation
- **Accept condition:** in_valid && in_ready, where in_ready = ~op_valid | out_ready. in_ready is combinational and does not depend on in_valid.
- **Fixed mode (mode = 0):** op = index of the lowest set bit of code. This is identical to the legacy 5-bit encoder when WIDTH = 5.
- **Round-robin mode (mode = 1):**
  - Search order is ptr+1, ptr+2, … wrapping modulo WIDTH, ending at ptr itself.
  - The first set bit in that order wins.
- **Pointer register ptr (IDXW bits):**
  - Reset and clr value: WIDTH-1, so the first round-robin search starts at bit 0.
  - Updates to the granted index on every accepted non-zero code, in either mode.
  - Unchanged when code is zero.
- **All-zero code:** op = 0, op_none = 1, oh = 0, op_valid = 1. The result is still delivered.
- **Output register:**
  - Loads on accept.
  - op_valid falls when out_ready && ~in_valid_accept.
  - Holds op/op_none/oh stable while op_valid && ~out_ready.
- **clr:**
  - Same cycle, clr has priority over accept: in_ready is forced to 0, no load occurs, op_valid goes to 0 and ptr goes to WIDTH-1.
  - Any pending result is discarded.
- **WIDTH not a power of two:** the search wraps at WIDTH, not at 2^IDXW. Bits at or above WIDTH do not exist.

## Timing
- **Latency:** 1 cycle. Code accepted at edge N appears on op with op_valid at edge N+1.
- **Throughput:** 1 result per cycle while out_ready = 1.
- **Reset values (async, immediate on rst_n low):** op = 0, op_none = 0, op_valid = 0, oh = 0, ptr = WIDTH-1.
- **Reset mid-operation:** any pending result is lost and nothing is replayed. The first accept after rst_n rises behaves as the first after power-up.
- **Back-to-back round robin:** a grant at edge N affects the search for code accepted at edge N+1, with no bubble. The pointer feeds the next search combinationally from its register.
- **Mode switch:** takes effect on the code accepted in the same cycle. ptr is not reset by a mode change.

## Configuration
- Macro: RRPE_ONEHOT_EN.
- **Defined:** port oh exists and equals 1 << op when op_none = 0, and 0 otherwise. It is registered with op and has the same timing.
- **Undefined:** oh port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 8 and IDXW = 3.
1. **Reset state:** assert rst_n low mid-stream with op_valid = 1 → op = 0, op_valid = 0, op_none = 0 immediately. Then, with mode = 1 and code = 8'hFF → op = 0.
2. **Fixed mode:** codes 8'b0001_0100, 8'h80, 8'h00 back-to-back with out_ready = 1 → op = 2, 7, 0. op_none = 0, 0, 1. op_valid is held high for 3 cycles.
3. **Round robin from reset:** code = 8'hFF for 9 consecutive accepts → op = 0,1,2,3,4,5,6,7,0.
   - Then code = 8'b0000_0101 after ptr = 0 → op = 2, then 0 (wrap).
4. **Backpressure:** out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 after the first load, op stable, ptr unchanged. Releasing out_ready gives the next result one cycle later, with no lost or duplicated grant.
5. **clr with in_valid on the same edge in round-robin mode after ptr = 5** → nothing accepted, op_valid = 0. The next accept of 8'hFF gives op = 0.
6. **RRPE_ONEHOT_EN build:** code = 8'b0110_0000 in fixed mode → op = 5, oh = 8'h20. code = 8'h00 → oh = 8'h00, op_none = 1.
